accel_exec_unit: RTL and testbench

//  Execution stage downstream of the accelerator register file (A/B/C/D, op, a/b/dest selects).

---
 rtl/accel_exec_unit.sv | 243 ++++++++++++++++++++++++
 tb/tb_accel_exec_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_exec_unit.sv
// Execution stage fed by the accelerator register file: captures an issued op
// with snapshotted operands, executes it (single-cycle ALU or iterative MUL/DIV)
// and returns the result as a one-cycle write-back with status flags.
module accel_exec_unit #(
   parameter int unsigned WIDTH      = 8,
   parameter bit          ENABLE_DIV = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [1:0]       a_sel,
   input  logic [1:0]       b_sel,
   input  logic [1:0]       dest_sel,
   input  logic [WIDTH-1:0] reg_a,
   input  logic [WIDTH-1:0] reg_b,
   input  logic [WIDTH-1:0] reg_c,
   input  logic [WIDTH-1:0] reg_d,
   output logic             busy,
   output logic             done,
   output logic             wb_en,
   output logic [1:0]       wb_sel,
   output logic [WIDTH-1:0] wb_data,
   output logic             flag_z,
   output logic             flag_c,
   output logic             flag_dz,
   output logic             flag_ill
);

   localparam int unsigned CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int unsigned PROD_W = 2 * WIDTH;
   localparam int unsigned SH_W   = 3;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   localparam logic [3:0] OP_NOP   = 4'h0;
   localparam logic [3:0] OP_ADD   = 4'h1;
   localparam logic [3:0] OP_SUB   = 4'h2;
   localparam logic [3:0] OP_AND   = 4'h3;
   localparam logic [3:0] OP_OR    = 4'h4;
   localparam logic [3:0] OP_XOR   = 4'h5;
   localparam logic [3:0] OP_SHL   = 4'h6;
   localparam logic [3:0] OP_SHR   = 4'h7;
   localparam logic [3:0] OP_MULLO = 4'h8;
   localparam logic [3:0] OP_MULHI = 4'h9;
   localparam logic [3:0] OP_DIVQ  = 4'hA;
   localparam logic [3:0] OP_DIVR  = 4'hB;
   localparam logic [3:0] OP_MIN   = 4'hC;
   localparam logic [3:0] OP_MAX   = 4'hD;
   localparam logic [3:0] OP_ROTL  = 4'hE;
   localparam logic [3:0] OP_PASS  = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_WB   = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [3:0]        op_q;
   logic [WIDTH-1:0]  a_q, b_q;
   logic [1:0]        dest_q;
   logic [CNT_W-1:0]  cnt;

   logic [PROD_W-1:0] acc, mcand;
   logic [WIDTH-1:0]  mplier;
   logic [WIDTH-1:0]  quo, rem;

   logic [PROD_W-1:0] acc_nxt, mcand_nxt;
   logic [WIDTH-1:0]  mplier_nxt;
   logic [WIDTH-1:0]  quo_nxt, rem_nxt;
   logic [WIDTH:0]    r_sh;

   logic [WIDTH-1:0]  a_mux, b_mux;
   logic [WIDTH-1:0]  res;
   logic [WIDTH:0]    sum, diff;
   logic [SH_W-1:0]   shamt;
   logic              carry, writes;
   logic              is_mul, is_div, is_ill, is_multi, dz, exec_done;

   // Source operand selection from the register file
   always_comb begin
      a_mux = reg_a;
      b_mux = reg_a;
      case (a_sel)
         2'd1:    a_mux = reg_b;
         2'd2:    a_mux = reg_c;
         2'd3:    a_mux = reg_d;
         default: a_mux = reg_a;
      endcase
      case (b_sel)
         2'd1:    b_mux = reg_b;
         2'd2:    b_mux = reg_c;
         2'd3:    b_mux = reg_d;
         default: b_mux = reg_a;
      endcase
   end

   // Opcode class decode and end-of-execute detection
   always_comb begin
      is_mul    = (op_q == OP_MULLO) || (op_q == OP_MULHI);
      is_div    = ENABLE_DIV && ((op_q == OP_DIVQ) || (op_q == OP_DIVR));
      is_ill    = !ENABLE_DIV && ((op_q == OP_DIVQ) || (op_q == OP_DIVR));
      is_multi  = is_mul || is_div;
      dz        = is_div && (b_q == '0);
      exec_done = (state == ST_EXEC) && (!is_multi || (cnt == CNT_LAST));
   end

   // One shift-add multiply step and one restoring-divide step
   always_comb begin
      acc_nxt    = mplier[0] ? (acc + mcand) : acc;
      mcand_nxt  = mcand << 1;
      mplier_nxt = mplier >> 1;
      r_sh       = {rem, quo[WIDTH-1]};
      if (r_sh >= {1'b0, b_q}) begin
         rem_nxt = WIDTH'(r_sh - {1'b0, b_q});
         quo_nxt = (quo << 1) | WIDTH'(1);
      end else begin
         rem_nxt = r_sh[WIDTH-1:0];
         quo_nxt = quo << 1;
      end
   end

   // Result mux; iterative ops take the value produced by their final step
   always_comb begin
      res    = '0;
      carry  = 1'b0;
      writes = 1'b1;
      shamt  = b_q[SH_W-1:0];
      sum    = {1'b0, a_q} + {1'b0, b_q};
      diff   = {1'b0, a_q} - {1'b0, b_q};
      case (op_q)
         OP_NOP:   writes = 1'b0;
         OP_ADD:   begin res = sum[WIDTH-1:0];  carry = sum[WIDTH];  end
         OP_SUB:   begin res = diff[WIDTH-1:0]; carry = diff[WIDTH]; end
         OP_AND:   res = a_q & b_q;
         OP_OR:    res = a_q | b_q;
         OP_XOR:   res = a_q ^ b_q;
         OP_SHL:   res = a_q << shamt;
         OP_SHR:   res = a_q >> shamt;
         OP_ROTL:  res = (a_q << shamt) | (a_q >> (WIDTH - 32'(shamt)));
         OP_MULLO: res = acc_nxt[WIDTH-1:0];
         OP_MULHI: res = acc_nxt[PROD_W-1:WIDTH];
         OP_DIVQ:  if (ENABLE_DIV) res = quo_nxt; else writes = 1'b0;
         OP_DIVR:  if (ENABLE_DIV) res = rem_nxt; else writes = 1'b0;
         OP_MIN:   res = (a_q < b_q) ? a_q : b_q;
         OP_MAX:   res = (a_q > b_q) ? a_q : b_q;
         OP_PASS:  res = a_q;
         default:  writes = 1'b0;
      endcase
   end

   // Next-state logic: IDLE -> EXEC -> WB -> IDLE
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start) state_nxt = ST_EXEC;
         ST_EXEC: if (exec_done) state_nxt = ST_WB;
         ST_WB:   state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Operand capture, iteration registers and registered write-back/flags
   always_ff @(posedge clk) begin
      if (rst) begin
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         dest_q   <= '0;
         cnt      <= '0;
         acc      <= '0;
         mcand    <= '0;
         mplier   <= '0;
         quo      <= '0;
         rem      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         wb_en    <= 1'b0;
         wb_sel   <= '0;
         wb_data  <= '0;
         flag_z   <= 1'b0;
         flag_c   <= 1'b0;
         flag_dz  <= 1'b0;
         flag_ill <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  op_q   <= op;
                  a_q    <= a_mux;
                  b_q    <= b_mux;
                  dest_q <= dest_sel;
                  cnt    <= '0;
                  acc    <= '0;
                  mcand  <= PROD_W'(a_mux);
                  mplier <= b_mux;
                  quo    <= a_mux;
                  rem    <= '0;
                  busy   <= 1'b1;
               end
            end
            ST_EXEC: begin
               cnt    <= cnt + CNT_W'(1);
               acc    <= acc_nxt;
               mcand  <= mcand_nxt;
               mplier <= mplier_nxt;
               quo    <= quo_nxt;
               rem    <= rem_nxt;
               if (exec_done) begin
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  wb_en    <= writes;
                  wb_sel   <= dest_q;
                  flag_c   <= carry;
                  flag_dz  <= dz;
                  flag_ill <= is_ill;
                  if (writes) begin
                     wb_data <= res;
                     flag_z  <= (res == '0);
                  end
               end
            end
            ST_WB: begin
               done  <= 1'b0;
               wb_en <= 1'b0;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               wb_en <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_accel_exec_unit.sv
// Directed bench for accel_exec_unit: expected write-backs are pushed to a
// scoreboard at issue and popped/checked when done arrives.
module tb_accel_exec_unit;

   logic       clk = 1'b0;
   logic       rst, start;
   logic [3:0] op;
   logic [1:0] a_sel, b_sel, dest_sel;
   logic [7:0] reg_a, reg_b, reg_c, reg_d;
   logic       busy, done, wb_en;
   logic [1:0] wb_sel;
   logic [7:0] wb_data;
   logic       flag_z, flag_c, flag_dz, flag_ill;

   typedef struct packed {
      logic [1:0] sel;
      logic [7:0] data;
      logic       wr;
      logic       z;
      logic       c;
      logic       dz;
      logic [7:0] lat;
   } exp_t;

   exp_t       sb[$];
   int         total = 0;
   int         bad   = 0;
   logic       exp_z = 1'b0;
   logic [7:0] last_data = 8'h00;

   accel_exec_unit #(.WIDTH(8), .ENABLE_DIV(1'b1)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op),
      .a_sel(a_sel), .b_sel(b_sel), .dest_sel(dest_sel),
      .reg_a(reg_a), .reg_b(reg_b), .reg_c(reg_c), .reg_d(reg_d),
      .busy(busy), .done(done), .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data),
      .flag_z(flag_z), .flag_c(flag_c), .flag_dz(flag_dz), .flag_ill(flag_ill)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [7:0] sel_reg(input logic [1:0] s);
      case (s)
         2'd0:    return reg_a;
         2'd1:    return reg_b;
         2'd2:    return reg_c;
         default: return reg_d;
      endcase
   endfunction

   // Reference behaviour built from native operators
   function automatic exp_t model(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                                  input logic [1:0] ds, input logic zprev);
      exp_t        e;
      logic [15:0] p;
      logic [8:0]  s;
      logic [7:0]  r;
      int          sh;
      e     = '0;
      e.sel = ds;
      e.wr  = 1'b1;
      e.lat = 8'd2;
      sh    = int'(b[2:0]);
      case (o)
         4'h0: e.wr = 1'b0;
         4'h1: begin s = {1'b0, a} + {1'b0, b}; e.data = s[7:0]; e.c = s[8]; end
         4'h2: begin e.data = a - b; e.c = (a < b); end
         4'h3: e.data = a & b;
         4'h4: e.data = a | b;
         4'h5: e.data = a ^ b;
         4'h6: e.data = a << sh;
         4'h7: e.data = a >> sh;
         4'h8: begin p = 16'(a) * 16'(b); e.data = p[7:0];  e.lat = 8'd9; end
         4'h9: begin p = 16'(a) * 16'(b); e.data = p[15:8]; e.lat = 8'd9; end
         4'hA: begin
            e.lat = 8'd9;
            if (b == 8'h00) begin e.data = 8'hFF; e.dz = 1'b1; end
            else e.data = a / b;
         end
         4'hB: begin
            e.lat = 8'd9;
            if (b == 8'h00) begin e.data = a; e.dz = 1'b1; end
            else e.data = a % b;
         end
         4'hC: e.data = (a < b) ? a : b;
         4'hD: e.data = (a > b) ? a : b;
         4'hE: begin
            r = a;
            for (int i = 0; i < sh; i++) r = {r[6:0], r[7]};
            e.data = r;
         end
         default: e.data = a;
      endcase
      e.z = e.wr ? (e.data == 8'h00) : zprev;
      return e;
   endfunction

   // Issue one op at a negedge in IDLE, wait for done, check against the scoreboard
   task automatic do_op(input logic [3:0] o, input logic [1:0] as, input logic [1:0] bs,
                        input logic [1:0] ds, input bit spam);
      exp_t       e;
      int         k;
      logic [7:0] sa, sb_, sc, sd;
      e     = model(o, sel_reg(as), sel_reg(bs), ds, exp_z);
      exp_z = e.z;
      sb.push_back(e);
      sa = reg_a; sb_ = reg_b; sc = reg_c; sd = reg_d;
      start = 1'b1; op = o; a_sel = as; b_sel = bs; dest_sel = ds;
      @(negedge clk);
      k = 1;
      start = 1'b0;
      chk("busy_exec", 32'(busy), 32'(1));
      while (done !== 1'b1 && k < 40) begin
         if (spam) begin
            start = k[0];
            op    = 4'($urandom_range(0, 15));
            a_sel = 2'($urandom_range(0, 3));
            reg_a = 8'($urandom);
            reg_b = 8'($urandom);
         end
         @(negedge clk);
         k++;
      end
      e = sb.pop_front();
      chk("done_seen", 32'(done), 32'(1));
      chk("latency", 32'(k), 32'(e.lat));
      chk("wb_en", 32'(wb_en), 32'(e.wr));
      chk("busy_wb", 32'(busy), 32'(0));
      if (e.wr) begin
         chk("wb_sel", 32'(wb_sel), 32'(e.sel));
         chk("wb_data", 32'(wb_data), 32'(e.data));
      end
      chk("flag_z", 32'(flag_z), 32'(e.z));
      chk("flag_c", 32'(flag_c), 32'(e.c));
      chk("flag_dz", 32'(flag_dz), 32'(e.dz));
      chk("flag_ill", 32'(flag_ill), 32'(0));
      last_data = wb_data;
      if (spam) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      reg_a = sa; reg_b = sb_; reg_c = sc; reg_d = sd;
      chk("done_pulse", 32'(done), 32'(0));
      chk("wb_en_pulse", 32'(wb_en), 32'(0));
      chk("busy_idle", 32'(busy), 32'(0));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'(0));
      chk({tag, "_done"}, 32'(done), 32'(0));
      chk({tag, "_wb_en"}, 32'(wb_en), 32'(0));
      chk({tag, "_wb_sel"}, 32'(wb_sel), 32'(0));
      chk({tag, "_wb_data"}, 32'(wb_data), 32'(0));
      chk({tag, "_flags"}, 32'({flag_z, flag_c, flag_dz, flag_ill}), 32'(0));
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; op = 4'h0;
      a_sel = 2'd0; b_sel = 2'd0; dest_sel = 2'd0;
      reg_a = 8'hF0; reg_b = 8'h20; reg_c = 8'h5A; reg_d = 8'h3C;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // ADD with carry out
      do_op(4'h1, 2'd0, 2'd1, 2'd2, 1'b0);
      chk("t1_add", 32'(last_data), 32'(8'h10));

      // MUL low then high half
      reg_a = 8'h0D; reg_b = 8'h0B;
      do_op(4'h8, 2'd0, 2'd1, 2'd3, 1'b0);
      chk("t2_mullo", 32'(last_data), 32'(8'h8F));
      do_op(4'h9, 2'd0, 2'd1, 2'd3, 1'b0);
      chk("t2_mulhi", 32'(last_data), 32'(8'h00));

      // DIV quotient/remainder and divide by zero
      reg_a = 8'h64; reg_b = 8'h07;
      do_op(4'hA, 2'd0, 2'd1, 2'd1, 1'b0);
      chk("t3_divq", 32'(last_data), 32'(8'h0E));
      do_op(4'hB, 2'd0, 2'd1, 2'd1, 1'b0);
      chk("t3_divr", 32'(last_data), 32'(8'h02));
      reg_b = 8'h00;
      do_op(4'hA, 2'd0, 2'd1, 2'd0, 1'b0);
      chk("t3_divz", 32'(last_data), 32'(8'hFF));

      // start pulses while busy are ignored; operands are snapshotted
      reg_a = 8'h0D; reg_b = 8'h0B;
      do_op(4'h8, 2'd0, 2'd1, 2'd1, 1'b1);
      chk("t4_mul_spam", 32'(last_data), 32'(8'h8F));
      do_op(4'h0, 2'd0, 2'd1, 2'd1, 1'b0);

      // Reset in the 4th EXEC cycle of a DIV aborts it
      reg_a = 8'h64; reg_b = 8'h00;
      do_op(4'hA, 2'd0, 2'd1, 2'd2, 1'b0);
      reg_b = 8'h07;
      start = 1'b1; op = 4'hA; a_sel = 2'd0; b_sel = 2'd1; dest_sel = 2'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk_all_zero("abort");
      rst = 1'b0;
      exp_z = 1'b0;
      begin
         int seen;
         seen = 0;
         for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1 || wb_en === 1'b1) seen++;
         end
         chk("abort_no_done", 32'(seen), 32'(0));
      end

      // Fresh ADD after abort, then shifts, rotate and SUB borrow
      reg_a = 8'hF0; reg_b = 8'h20;
      do_op(4'h1, 2'd0, 2'd1, 2'd2, 1'b0);
      chk("t5_add", 32'(last_data), 32'(8'h10));
      reg_a = 8'h81; reg_b = 8'h01;
      do_op(4'h6, 2'd0, 2'd1, 2'd0, 1'b0);
      chk("t6_shl", 32'(last_data), 32'(8'h02));
      do_op(4'hE, 2'd0, 2'd1, 2'd0, 1'b0);
      chk("t6_rotl", 32'(last_data), 32'(8'h03));
      reg_a = 8'h00; reg_b = 8'h01;
      do_op(4'h2, 2'd0, 2'd1, 2'd3, 1'b0);
      chk("t6_sub", 32'(last_data), 32'(8'hFF));
      chk("t6_sub_c", 32'(flag_c), 32'(1));

      // Every opcode with varied operands from regC/regD
      for (int i = 0; i < 16; i++) begin
         reg_c = 8'($urandom);
         reg_d = (i == 10) ? 8'h00 : 8'($urandom_range(1, 255));
         do_op(4'(i), 2'd2, 2'd3, 2'(i), 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
